// File: rtl/out_fft_pkg.sv
// Shared constants and address helpers for the FFT output reorder buffer.
package out_fft_pkg;

  localparam int DWL_DEF   = 16;
  localparam int AWL_DEF   = 8;
  localparam int NUM_BANKS = 2;
  localparam int MAX_AWL   = 16;

  typedef logic [MAX_AWL-1:0] max_addr_t;

  // Shifting LSB-first into the result leaves bit 0 of addr at position log2n-1.
  function automatic max_addr_t bitrev_var(input max_addr_t addr, input int unsigned log2n);
    max_addr_t r;
    max_addr_t a;
    r = '0;
    a = addr;
    for (int unsigned i = 0; i < MAX_AWL; i++) begin
      if (i < log2n) begin
        r = {r[MAX_AWL-2:0], a[0]};
      end
      a = a >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned clamp_log2n(input int unsigned log2n, input int unsigned awl);
    return ((log2n == 0) || (log2n > awl)) ? awl : log2n;
  endfunction

endpackage

// File: rtl/out_fft_bank_ram.sv
// One reorder bank: true dual-port RAM, port A write-only, port B write or read.
module out_fft_bank_ram #(
  parameter int AWL = 8,
  parameter int W   = 32
) (
  input  logic           clk_i,
  input  logic           a_we_i,
  input  logic [AWL-1:0] a_addr_i,
  input  logic [W-1:0]   a_wdata_i,
  input  logic           b_we_i,
  input  logic [AWL-1:0] b_addr_i,
  input  logic [W-1:0]   b_wdata_i,
  output logic [W-1:0]   b_rdata_o
);

  logic [W-1:0] mem_q [1<<AWL];

  // NOTE: the storage array has no reset; clearing it would force flops instead of a RAM macro.
  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    if (b_we_i) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end else begin
      b_rdata_o <= mem_q[b_addr_i];
    end
  end

endmodule

// File: rtl/out_fft_reorder_buf.sv
// Ping-pong reorder buffer: pairs from the last FFT stage in, one sample per cycle
// out in natural or bit-reversed order through a 2-entry skid buffer.
module out_fft_reorder_buf
  import out_fft_pkg::*;
#(
  parameter int DWL = DWL_DEF,
  parameter int AWL = AWL_DEF,
  parameter int LNW = $clog2(AWL + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [LNW-1:0] CFG_LOG2N,
  input  logic           CFG_BITREV,
  input  logic           WR_VALID,
  output logic           WR_READY,
  input  logic [DWL-1:0] WR_DATA_1_R,
  input  logic [DWL-1:0] WR_DATA_1_I,
  input  logic [DWL-1:0] WR_DATA_2_R,
  input  logic [DWL-1:0] WR_DATA_2_I,
  output logic           R_VALID,
  input  logic           R_READY,
  output logic [DWL-1:0] R_DATA_R,
  output logic [DWL-1:0] R_DATA_I,
  output logic           R_LAST,
  output logic [1:0]     BANK_FULL
);

  localparam int RW = 2 * DWL;

  typedef logic [AWL-1:0] addr_t;
  typedef logic [RW-1:0]  word_t;
  typedef struct packed {
    word_t data;
    logic  last;
  } skid_t;

  logic                 wr_bank_q, wr_bank_d;
  addr_t                pair_cnt_q, pair_cnt_d;
  logic [NUM_BANKS-1:0] bank_full_q, bank_full_d;
  logic [LNW-1:0]       cfg_log2n_q [NUM_BANKS];
  logic [LNW-1:0]       cfg_log2n_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] cfg_bitrev_q, cfg_bitrev_d;

  logic                 iss_bank_q, iss_bank_d;
  addr_t                rd_cnt_q, rd_cnt_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_pend_bank_q, rd_pend_bank_d;
  logic                 rd_pend_last_q, rd_pend_last_d;

  skid_t                skid_q [2];
  skid_t                skid_d [2];
  logic                 skid_wp_q, skid_wp_d;
  logic                 skid_rp_q, skid_rp_d;
  logic [1:0]           skid_cnt_q, skid_cnt_d;

  logic                 wr_fire, wr_last;
  logic [LNW-1:0]       wr_log2n;
  addr_t                wr_half, wr_b_addr;
  logic                 iss_fire, iss_last;
  logic [LNW-1:0]       iss_log2n;
  addr_t                iss_n_m1, iss_addr, iss_addr_rev;
  logic                 pop;
  logic [1:0]           occ_after;
  skid_t                skid_head;
  word_t                ram_rdata [NUM_BANKS];

  // Config for the first pair of a frame comes straight from the inputs; later pairs use the latched copy.
  assign wr_log2n  = (pair_cnt_q == '0) ? LNW'(clamp_log2n(32'(CFG_LOG2N), AWL))
                                        : cfg_log2n_q[wr_bank_q];
  assign wr_half   = addr_t'(1) << (wr_log2n - LNW'(1));
  assign wr_b_addr = pair_cnt_q + wr_half;
  assign wr_last   = (pair_cnt_q == wr_half - addr_t'(1));
  assign WR_READY  = RST && !bank_full_q[wr_bank_q];
  assign wr_fire   = WR_VALID && WR_READY;

  assign skid_head = skid_q[skid_rp_q];
  assign R_VALID   = (skid_cnt_q != 2'd0);
  assign R_LAST    = R_VALID && skid_head.last;
  assign R_DATA_R  = skid_head.data[RW-1:DWL];
  assign R_DATA_I  = skid_head.data[DWL-1:0];
  assign BANK_FULL = bank_full_q;
  assign pop       = R_VALID && R_READY;

  // A read is only launched if the skid can absorb it next cycle, counting the one still in the RAM.
  assign occ_after    = skid_cnt_q + 2'(rd_pend_q) - 2'(pop);
  assign iss_log2n    = cfg_log2n_q[iss_bank_q];
  assign iss_n_m1     = (addr_t'(1) << iss_log2n) - addr_t'(1);
  assign iss_last     = (rd_cnt_q == iss_n_m1);
  assign iss_addr_rev = addr_t'(bitrev_var(max_addr_t'(rd_cnt_q), 32'(iss_log2n)));
  assign iss_addr     = cfg_bitrev_q[iss_bank_q] ? iss_addr_rev : rd_cnt_q;
  assign iss_fire     = bank_full_q[iss_bank_q] && (occ_after < 2'd2);

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic sel_wr;
    assign sel_wr = wr_fire && (wr_bank_q == 1'(g));

    out_fft_bank_ram #(
      .AWL (AWL),
      .W   (RW)
    ) u_ram (
      .clk_i     (CLK),
      .a_we_i    (sel_wr),
      .a_addr_i  (pair_cnt_q),
      .a_wdata_i ({WR_DATA_1_R, WR_DATA_1_I}),
      .b_we_i    (sel_wr),
      .b_addr_i  (sel_wr ? wr_b_addr : iss_addr),
      .b_wdata_i ({WR_DATA_2_R, WR_DATA_2_I}),
      .b_rdata_o (ram_rdata[g])
    );
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    wr_bank_d      = wr_bank_q;
    pair_cnt_d     = pair_cnt_q;
    bank_full_d    = bank_full_q;
    cfg_log2n_d    = cfg_log2n_q;
    cfg_bitrev_d   = cfg_bitrev_q;
    iss_bank_d     = iss_bank_q;
    rd_cnt_d       = rd_cnt_q;
    rd_bank_d      = rd_bank_q;
    rd_pend_d      = iss_fire;
    rd_pend_bank_d = iss_bank_q;
    rd_pend_last_d = iss_last;
    skid_d         = skid_q;
    skid_wp_d      = skid_wp_q;
    skid_rp_d      = skid_rp_q;
    skid_cnt_d     = skid_cnt_q + 2'(rd_pend_q) - 2'(pop);

    if (wr_fire) begin
      if (pair_cnt_q == '0) begin
        cfg_log2n_d[wr_bank_q]  = wr_log2n;
        cfg_bitrev_d[wr_bank_q] = CFG_BITREV;
      end
      if (wr_last) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        pair_cnt_d             = '0;
      end else begin
        pair_cnt_d = pair_cnt_q + addr_t'(1);
      end
    end

    if (iss_fire) begin
      if (iss_last) begin
        rd_cnt_d   = '0;
        iss_bank_d = ~iss_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + addr_t'(1);
      end
    end

    if (rd_pend_q) begin
      skid_d[skid_wp_q] = {ram_rdata[rd_pend_bank_q], rd_pend_last_q};
      skid_wp_d         = ~skid_wp_q;
    end

    if (pop) begin
      skid_rp_d = ~skid_rp_q;
      if (skid_head.last) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = ~rd_bank_q;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_bank_q      <= 1'b0;
      pair_cnt_q     <= '0;
      bank_full_q    <= '0;
      cfg_bitrev_q   <= '0;
      iss_bank_q     <= 1'b0;
      rd_cnt_q       <= '0;
      rd_bank_q      <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_pend_bank_q <= 1'b0;
      rd_pend_last_q <= 1'b0;
      skid_wp_q      <= 1'b0;
      skid_rp_q      <= 1'b0;
      skid_cnt_q     <= 2'd0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        cfg_log2n_q[b] <= '0;
      end
      for (int s = 0; s < 2; s++) begin
        skid_q[s] <= '0;
      end
    end else begin
      wr_bank_q      <= wr_bank_d;
      pair_cnt_q     <= pair_cnt_d;
      bank_full_q    <= bank_full_d;
      cfg_log2n_q    <= cfg_log2n_d;
      cfg_bitrev_q   <= cfg_bitrev_d;
      iss_bank_q     <= iss_bank_d;
      rd_cnt_q       <= rd_cnt_d;
      rd_bank_q      <= rd_bank_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_bank_q <= rd_pend_bank_d;
      rd_pend_last_q <= rd_pend_last_d;
      skid_q         <= skid_d;
      skid_wp_q      <= skid_wp_d;
      skid_rp_q      <= skid_rp_d;
      skid_cnt_q     <= skid_cnt_d;
    end
  end

endmodule

// File: tb/tb_out_fft_reorder_buf.sv
// Directed bench for out_fft_reorder_buf: table of small frames plus multi-frame,
// back-pressure, config-latch and reset sequences.
module tb_out_fft_reorder_buf;

  localparam int DWL = 16;
  localparam int AWL = 8;
  localparam int LNW = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [LNW-1:0] CFG_LOG2N = '0;
  logic           CFG_BITREV = 1'b0;
  logic           WR_VALID = 1'b0;
  logic           WR_READY;
  logic [DWL-1:0] WR_DATA_1_R = '0, WR_DATA_1_I = '0, WR_DATA_2_R = '0, WR_DATA_2_I = '0;
  logic           R_VALID;
  logic           R_READY = 1'b0;
  logic [DWL-1:0] R_DATA_R, R_DATA_I;
  logic           R_LAST;
  logic [1:0]     BANK_FULL;

  out_fft_reorder_buf #(.DWL(DWL), .AWL(AWL), .LNW(LNW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CFG_LOG2N   (CFG_LOG2N),
    .CFG_BITREV  (CFG_BITREV),
    .WR_VALID    (WR_VALID),
    .WR_READY    (WR_READY),
    .WR_DATA_1_R (WR_DATA_1_R),
    .WR_DATA_1_I (WR_DATA_1_I),
    .WR_DATA_2_R (WR_DATA_2_R),
    .WR_DATA_2_I (WR_DATA_2_I),
    .R_VALID     (R_VALID),
    .R_READY     (R_READY),
    .R_DATA_R    (R_DATA_R),
    .R_DATA_I    (R_DATA_I),
    .R_LAST      (R_LAST),
    .BANK_FULL   (BANK_FULL)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [DWL-1:0] r;
    logic [DWL-1:0] i;
    logic           last;
    int             cyc;
  } smp_t;

  smp_t got_q[$];

  logic              hold_prev = 1'b0;
  logic [2*DWL:0]    hold_val  = '0;

  always @(negedge CLK) begin
    if (hold_prev) begin
      check("hold_stable", {R_VALID, R_DATA_R, R_DATA_I, R_LAST}, {1'b1, hold_val});
    end
    hold_prev = RST && R_VALID && !R_READY;
    hold_val  = {R_DATA_R, R_DATA_I, R_LAST};
    if (RST && R_VALID && R_READY) begin
      got_q.push_back('{R_DATA_R, R_DATA_I, R_LAST, cyc});
    end
  end

  function automatic logic [DWL-1:0] mk(input int tag, input int addr);
    return DWL'((tag << 8) | (addr & 255));
  endfunction

  function automatic int ref_addr(input int j, input int log2n, input bit br);
    int r;
    r = 0;
    if (!br) return j;
    for (int b = 0; b < log2n; b++) begin
      if ((j & (1 << b)) != 0) r = r | (1 << (log2n - 1 - b));
    end
    return r;
  endfunction

  function automatic smp_t get_smp(input int k);
    smp_t s;
    s.r = 'x; s.i = 'x; s.last = 1'bx; s.cyc = -1;
    if (k < got_q.size()) s = got_q[k];
    return s;
  endfunction

  task automatic write_pair(input logic [LNW-1:0] cfg, input bit br, input int tag,
                            input int a1, input int a2);
    bit acc;
    CFG_LOG2N   = cfg;
    CFG_BITREV  = br;
    WR_VALID    = 1'b1;
    WR_DATA_1_R = mk(tag, a1);
    WR_DATA_1_I = DWL'(-mk(tag, a1));
    WR_DATA_2_R = mk(tag, a2);
    WR_DATA_2_I = DWL'(-mk(tag, a2));
    acc = 1'b0;
    for (int t = 0; t < 3000 && !acc; t++) begin
      @(negedge CLK);
      acc = WR_READY;
      @(posedge CLK);
      #1;
    end
    check("wr_accept", acc, 1'b1);
  endtask

  task automatic write_frame(input int log2n, input logic [LNW-1:0] cfg0,
                             input logic [LNW-1:0] cfg_rest, input bit br, input int tag);
    int n;
    n = 1 << log2n;
    for (int k = 0; k < n / 2; k++) begin
      write_pair((k == 0) ? cfg0 : cfg_rest, br, tag, k, k + n / 2);
    end
    WR_VALID = 1'b0;
  endtask

  task automatic wait_samples(input int cnt, input int limit);
    int t;
    t = 0;
    while (got_q.size() < cnt && t < limit) begin
      @(posedge CLK);
      #1;
      t++;
    end
    check("samples_arrived", got_q.size() >= cnt, 1'b1);
  endtask

  task automatic check_frame(input string name, input int base, input int log2n,
                             input bit br, input int tag);
    int n;
    logic [DWL-1:0] e;
    smp_t s;
    n = 1 << log2n;
    for (int j = 0; j < n; j++) begin
      e = mk(tag, ref_addr(j, log2n, br));
      s = get_smp(base + j);
      check(name, {s.r, s.i, s.last}, {e, DWL'(-e), 1'(j == n - 1)});
    end
  endtask

  typedef struct {
    int log2n;
    bit br;
    int n;
    int exp[16];
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, summary %0d checks %0d failures",
             n_checks, n_fail);
    $fatal(1);
  end

  initial begin : main
    int lat;
    smp_t s0, s1;

    vecs[0].log2n = 3; vecs[0].br = 1'b1; vecs[0].n = 8;
    vecs[0].exp = '{0, 4, 2, 6, 1, 5, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].log2n = 3; vecs[1].br = 1'b0; vecs[1].n = 8;
    vecs[1].exp = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].log2n = 1; vecs[2].br = 1'b1; vecs[2].n = 2;
    vecs[2].exp = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3].log2n = 2; vecs[3].br = 1'b1; vecs[3].n = 4;
    vecs[3].exp = '{0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].log2n = 4; vecs[4].br = 1'b1; vecs[4].n = 16;
    vecs[4].exp = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    // Reset state
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_wr_ready", WR_READY, 1'b0);
    check("rst_r_valid", R_VALID, 1'b0);
    check("rst_r_last", R_LAST, 1'b0);
    check("rst_r_data", {R_DATA_R, R_DATA_I}, 32'h0);
    check("rst_bank_full", BANK_FULL, 2'b00);
    RST = 1'b1;
    #1;
    check("wr_ready_after_rst", WR_READY, 1'b1);

    // Table of single frames, sink always ready
    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      R_READY = 1'b1;
      write_frame(vecs[v].log2n, LNW'(vecs[v].log2n), LNW'(vecs[v].log2n), vecs[v].br, 0);
      if (v == 0) begin
        lat = 0;
        for (int t = 0; t < 20; t++) begin
          @(negedge CLK);
          if (R_VALID) break;
          lat++;
        end
        check("first_valid_latency", lat, 2);
      end
      wait_samples(vecs[v].n, 100);
      for (int j = 0; j < vecs[v].n; j++) begin
        s0 = get_smp(j);
        check("table_sample", {s0.r, s0.i, s0.last},
              {DWL'(vecs[v].exp[j]), DWL'(-vecs[v].exp[j]), 1'(j == vecs[v].n - 1)});
      end
      check("table_bank_full_clear", BANK_FULL, 2'b00);
    end

    // Both banks full under back-pressure, then release
    R_READY = 1'b0;
    got_q.delete();
    write_frame(4, 4'd4, 4'd4, 1'b0, 1);
    write_frame(4, 4'd4, 4'd4, 1'b0, 2);
    repeat (3) @(posedge CLK);
    #1;
    check("both_full", BANK_FULL, 2'b11);
    check("wr_blocked", WR_READY, 1'b0);
    fork
      write_frame(4, 4'd4, 4'd4, 1'b0, 3);
      begin
        repeat (3) @(posedge CLK);
        #1;
        check("still_blocked", WR_READY, 1'b0);
        R_READY = 1'b1;
        wait_samples(16, 200);
        check("wr_ready_after_drain", WR_READY, 1'b1);
      end
    join
    wait_samples(48, 300);
    check_frame("full_f1", 0, 4, 1'b0, 1);
    check_frame("full_f2", 16, 4, 1'b0, 2);
    check_frame("full_f3", 32, 4, 1'b0, 3);

    // Three N=256 bit-reversed frames with ~30% sink stalls
    got_q.delete();
    fork
      begin
        for (int f = 0; f < 3; f++) write_frame(8, 4'd8, 4'd8, 1'b1, 4 + f);
      end
      begin
        for (int g = 0; g < 6000 && got_q.size() < 768; g++) begin
          @(posedge CLK);
          #1;
          R_READY = ($urandom_range(0, 99) >= 30);
        end
        R_READY = 1'b1;
      end
    join
    wait_samples(768, 500);
    repeat (10) @(posedge CLK);
    #1;
    check("stall_count", got_q.size(), 768);
    for (int f = 0; f < 3; f++) check_frame("stall_frame", f * 256, 8, 1'b1, 4 + f);

    // Mid-frame config change keeps N=8
    got_q.delete();
    R_READY = 1'b1;
    write_frame(3, 4'd3, 4'd5, 1'b1, 10);
    wait_samples(8, 100);
    repeat (10) @(posedge CLK);
    #1;
    check("midcfg_count", got_q.size(), 8);
    check_frame("midcfg", 0, 3, 1'b1, 10);

    // Out-of-range CFG_LOG2N clamps to 256; back-to-back frames stream with no gap
    got_q.delete();
    write_frame(8, 4'd0, 4'd0, 1'b0, 11);
    write_frame(8, 4'd9, 4'd9, 1'b1, 12);
    wait_samples(512, 1000);
    check_frame("cfg0_frame", 0, 8, 1'b0, 11);
    check_frame("cfg9_frame", 256, 8, 1'b1, 12);
    s0 = get_smp(0);
    s1 = get_smp(511);
    check("no_gap", s1.cyc - s0.cyc, 511);
    s0 = get_smp(255);
    s1 = get_smp(256);
    check("boundary_gap", s1.cyc - s0.cyc, 1);

    // One-cycle reset mid-drain, then a fresh frame
    got_q.delete();
    write_frame(3, 4'd3, 4'd3, 1'b1, 13);
    wait_samples(3, 100);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("midrst_r_valid", R_VALID, 1'b0);
    check("midrst_bank_full", BANK_FULL, 2'b00);
    check("midrst_wr_ready", WR_READY, 1'b0);
    RST = 1'b1;
    got_q.delete();
    write_frame(3, 4'd3, 4'd3, 1'b1, 14);
    wait_samples(8, 100);
    repeat (6) @(posedge CLK);
    #1;
    check("postrst_count", got_q.size(), 8);
    check_frame("postrst_frame", 0, 3, 1'b1, 14);
    check("postrst_bank_full", BANK_FULL, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
